// File: rtl/e2p_seq_pkg.sv
// Shared types and constants for the EEPROM request sequencer: state encoding,
// record geometry, counter width and default timing values.
package e2p_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREQ,
    ST_WWAIT,
    ST_RREQ,
    ST_DONE
  } e2p_state_t;

  localparam int unsigned WORD_NUM        = 4;
  localparam int unsigned ADDR_STEP       = 4;
  localparam int unsigned IDX_W           = $clog2(WORD_NUM);
  localparam int unsigned CNT_W           = 21;
  localparam int unsigned WR_WAIT_CYC_DEF = 625000;
  localparam int unsigned TO_CYC_DEF      = 1250000;

  // Byte address of word idx of a record; wraps modulo 2^16.
  function automatic logic [15:0] word_addr_of(input logic [15:0] base,
                                               input logic [IDX_W-1:0] idx);
    return 16'(base + 16'(ADDR_STEP * idx));
  endfunction

endpackage

// File: rtl/e2p_cyc_cnt.sv
// Loadable down-counter with zero flag; shared by the EEPROM write-time wait
// and the per-word handshake timeout. Decrement saturates at zero.
module e2p_cyc_cnt #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/e2p_req_seq.sv
// EEPROM request sequencer: turns UART read/write pulses into word-engine
// requests (4-word writes with tWR wait, single-word reads).
// Optional macro E2P_TIMEOUT_EN adds a per-word handshake timeout with e2p_err.
module e2p_req_seq
  import e2p_seq_pkg::*;
#(
  parameter int unsigned WR_WAIT_CYC = WR_WAIT_CYC_DEF,
  parameter int unsigned TO_CYC      = TO_CYC_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        e2p_rw_sel,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [31:0] wr_value0,
  input  logic [31:0] wr_value1,
  input  logic [31:0] wr_value2,
  input  logic [31:0] wr_value3,
  output logic        wr_done,
  output logic        e2p_busy,
  output logic        e2p_urd_dval,
  output logic [31:0] e2p_rd_value,
  output logic        word_req,
  output logic        word_rw,
  output logic [15:0] word_addr,
  output logic [31:0] word_wdata,
  input  logic        word_done,
  input  logic [31:0] word_rdata,
  output logic        e2p_err
);

`ifdef E2P_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  e2p_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [15:0]      addr_q;
  logic [31:0]      val_q   [WORD_NUM];
  logic [31:0]      wr_vals [WORD_NUM];

  logic             cap_wr, cap_rd;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             err_nxt, dval_nxt, req_nxt;
  logic [15:0]      base_nxt;
  logic [31:0]      data_nxt;

  always_comb begin
    wr_vals[0] = wr_value0;
    wr_vals[1] = wr_value1;
    wr_vals[2] = wr_value2;
    wr_vals[3] = wr_value3;
  end

  e2p_cyc_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk_sys),
    .rst_n    (rst_sys_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cap_wr    = 1'b0;
    cap_rd    = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    err_nxt   = 1'b0;
    dval_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Write wins over a simultaneous read.
        if (e2p_rw_sel && wr_en) begin
          state_nxt = ST_WREQ;
          idx_nxt   = '0;
          cap_wr    = 1'b1;
          cnt_load  = TO_EN;
          cnt_val   = CNT_W'(TO_CYC);
        end else if (e2p_rw_sel && rd_en) begin
          state_nxt = ST_RREQ;
          idx_nxt   = '0;
          cap_rd    = 1'b1;
          cnt_load  = TO_EN;
          cnt_val   = CNT_W'(TO_CYC);
        end
      end
      ST_WREQ: begin
        if (word_done) begin
          state_nxt = ST_WWAIT;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(WR_WAIT_CYC);
        end else if (TO_EN) begin
          if (cnt_zero) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_WWAIT: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (idx == IDX_W'(WORD_NUM - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WREQ;
          idx_nxt   = idx + IDX_W'(1);
          cnt_load  = TO_EN;
          cnt_val   = CNT_W'(TO_CYC);
        end
      end
      ST_RREQ: begin
        if (word_done) begin
          state_nxt = ST_IDLE;
          dval_nxt  = 1'b1;
        end else if (TO_EN) begin
          if (cnt_zero) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Engine outputs are registered from next-state values so they appear with
  // word_req and cannot change while it is high.
  always_comb begin
    req_nxt  = (state_nxt == ST_WREQ) || (state_nxt == ST_RREQ);
    base_nxt = (cap_wr || cap_rd) ? wr_addr : addr_q;
    data_nxt = cap_wr ? wr_vals[idx_nxt] : val_q[idx_nxt];
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      addr_q       <= '0;
      for (int unsigned k = 0; k < WORD_NUM; k++) val_q[k] <= '0;
      word_req     <= 1'b0;
      word_rw      <= 1'b0;
      word_addr    <= '0;
      word_wdata   <= '0;
      wr_done      <= 1'b0;
      e2p_busy     <= 1'b0;
      e2p_urd_dval <= 1'b0;
      e2p_rd_value <= '0;
      e2p_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap_wr || cap_rd) addr_q <= wr_addr;
      if (cap_wr) begin
        for (int unsigned k = 0; k < WORD_NUM; k++) val_q[k] <= wr_vals[k];
      end
      word_req <= req_nxt;
      if (req_nxt) begin
        word_rw   <= (state_nxt == ST_RREQ);
        word_addr <= word_addr_of(base_nxt, idx_nxt);
        if (state_nxt == ST_WREQ) word_wdata <= data_nxt;
      end
      wr_done      <= (state_nxt == ST_DONE);
      e2p_busy     <= (state_nxt != ST_IDLE);
      e2p_urd_dval <= dval_nxt;
      if (dval_nxt) e2p_rd_value <= word_rdata;
      e2p_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_e2p_req_seq.sv
// Directed bench for e2p_req_seq: table-driven read/select vectors plus
// hand-written write, wrap/collision, busy, timeout and reset sequences.
module tb_e2p_req_seq;

  localparam int unsigned WR_WAIT = 8;
  localparam int unsigned TO      = 16;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        e2p_rw_sel = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [31:0] wr_value0 = '0, wr_value1 = '0, wr_value2 = '0, wr_value3 = '0;
  logic        wr_done, e2p_busy, e2p_urd_dval, word_req, word_rw, e2p_err;
  logic [31:0] e2p_rd_value, word_wdata;
  logic [15:0] word_addr;
  logic        word_done = 1'b0;
  logic [31:0] word_rdata = '0;

  e2p_req_seq #(
    .WR_WAIT_CYC(WR_WAIT),
    .TO_CYC     (TO)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .e2p_rw_sel   (e2p_rw_sel),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_value0    (wr_value0),
    .wr_value1    (wr_value1),
    .wr_value2    (wr_value2),
    .wr_value3    (wr_value3),
    .wr_done      (wr_done),
    .e2p_busy     (e2p_busy),
    .e2p_urd_dval (e2p_urd_dval),
    .e2p_rd_value (e2p_rd_value),
    .word_req     (word_req),
    .word_rw      (word_rw),
    .word_addr    (word_addr),
    .word_wdata   (word_wdata),
    .word_done    (word_done),
    .word_rdata   (word_rdata),
    .e2p_err      (e2p_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
  } req_t;

  int total = 0;
  int bad   = 0;

  // Engine model and monitor state
  bit          eng_en = 1'b1;
  bit          eng_busy = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_rdata = '0;
  req_t        req_q[$];
  int          gap_q[$];
  req_t        cur;
  bit          prev_req = 1'b0;
  bit          seen_req = 1'b0;
  int          low_run = 0;
  int          hi_run = 0;
  int          last_hi = 0;
  int          n_done = 0, n_dval = 0, n_err = 0, unstable = 0;

  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      word_done = 1'b0;
      if (!word_req) begin
        eng_busy = 1'b0;
        eng_cnt  = 0;
      end else if (eng_en && !eng_busy) begin
        eng_cnt++;
        if (eng_cnt == 3) begin
          word_done  = 1'b1;
          word_rdata = eng_rdata;
          eng_cnt    = 0;
          eng_busy   = 1'b1;
        end
      end
      if (word_req && !prev_req) begin
        cur = '{rw: word_rw, addr: word_addr, data: word_wdata};
        req_q.push_back(cur);
        if (seen_req) gap_q.push_back(low_run);
        seen_req = 1'b1;
        low_run  = 0;
        hi_run   = 1;
      end else if (word_req) begin
        hi_run++;
        if ({word_rw, word_addr, word_wdata} != cur) unstable++;
      end else begin
        if (prev_req) last_hi = hi_run;
        if (seen_req) low_run++;
      end
      if (!e2p_busy) seen_req = 1'b0;
      prev_req = word_req;
      if (wr_done)      n_done++;
      if (e2p_urd_dval) n_dval++;
      if (e2p_err)      n_err++;
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mon;
    req_q.delete();
    gap_q.delete();
    n_done = 0; n_dval = 0; n_err = 0; unstable = 0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (e2p_busy && n < max) begin
      tick();
      n++;
    end
    chk({name, " idle"}, 32'(e2p_busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic start_write(input logic [15:0] a, input logic [3:0][31:0] v, input bit with_rd);
    wr_addr   = a;
    wr_value0 = v[0]; wr_value1 = v[1]; wr_value2 = v[2]; wr_value3 = v[3];
    wr_en = 1'b1;
    rd_en = with_rd;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check_write(input string nm, input logic [15:0] a, input logic [3:0][31:0] v);
    logic [15:0] ea;
    chk({nm, " nreq"}, 32'(req_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < req_q.size(); k++) begin
      ea = a + 16'(4 * k);
      chk($sformatf("%s rw%0d", nm, k), 32'(req_q[k].rw), 32'd0);
      chk($sformatf("%s addr%0d", nm, k), 32'(req_q[k].addr), 32'(ea));
      chk($sformatf("%s data%0d", nm, k), req_q[k].data, v[k]);
    end
    chk({nm, " ngap"}, 32'(gap_q.size()), 32'd3);
    for (int k = 0; k < gap_q.size(); k++)
      chk($sformatf("%s gap%0d", nm, k), 32'(gap_q[k]), 32'(WR_WAIT + 1));
    chk({nm, " wr_done"}, 32'(n_done), 32'd1);
    chk({nm, " dval"}, 32'(n_dval), 32'd0);
    chk({nm, " err"}, 32'(n_err), 32'd0);
    chk({nm, " stable"}, 32'(unstable), 32'd0);
  endtask

  typedef struct {
    logic        sel, rd, wr;
    logic [15:0] addr;
    logic [31:0] rdata;
    int          exp_nreq;
    logic [15:0] exp_addr;
    int          exp_dval;
    logic [31:0] exp_value;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [3:0][31:0] v1, v2, v3;
    int n;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h0020, 32'hDEADBEEF, 1, 16'h0020, 1, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0040, 32'h12345678, 0, 16'h0000, 0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'hFFFF, 32'hA5A55A5A, 1, 16'hFFFF, 1, 32'hA5A55A5A};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0300, 32'h0BADF00D, 0, 16'h0000, 0, 32'hA5A55A5A};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h1234, 32'h00000000, 1, 16'h1234, 1, 32'h00000000};
    v1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    v2 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    v3 = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

    // Reset state
    repeat (3) tick();
    chk("rst word_req", 32'(word_req), 32'd0);
    chk("rst busy", 32'(e2p_busy), 32'd0);
    chk("rst word_addr", 32'(word_addr), 32'd0);
    chk("rst rd_value", e2p_rd_value, 32'd0);
    chk("rst wr_done", 32'(wr_done), 32'd0);
    rst_sys_n = 1'b1;
    tick();
    chk("post-rst busy", 32'(e2p_busy), 32'd0);

    // Read / select vectors
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      eng_rdata  = vecs[i].rdata;
      e2p_rw_sel = vecs[i].sel;
      rd_en      = vecs[i].rd;
      wr_en      = vecs[i].wr;
      wr_addr    = vecs[i].addr;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      e2p_rw_sel = 1'b1;
      wait_idle($sformatf("vec%0d", i), 100);
      chk($sformatf("vec%0d nreq", i), 32'(req_q.size()), 32'(vecs[i].exp_nreq));
      if (vecs[i].exp_nreq > 0 && req_q.size() > 0) begin
        chk($sformatf("vec%0d rw", i), 32'(req_q[0].rw), 32'd1);
        chk($sformatf("vec%0d addr", i), 32'(req_q[0].addr), 32'(vecs[i].exp_addr));
      end
      chk($sformatf("vec%0d dval", i), 32'(n_dval), 32'(vecs[i].exp_dval));
      chk($sformatf("vec%0d rd_value", i), e2p_rd_value, vecs[i].exp_value);
      chk($sformatf("vec%0d wr_done", i), 32'(n_done), 32'd0);
    end

    // Four-word write at 0x0100
    clear_mon();
    start_write(16'h0100, v1, 1'b0);
    chk("wr req_rise", 32'(word_req), 32'd1);
    chk("wr busy_rise", 32'(e2p_busy), 32'd1);
    n = 0;
    while (!wr_done && n < 300) begin
      tick();
      n++;
    end
    chk("wr done_seen", 32'(wr_done), 32'd1);
    chk("wr busy_at_done", 32'(e2p_busy), 32'd1);
    tick();
    chk("wr done_width", 32'(wr_done), 32'd0);
    chk("wr busy_after", 32'(e2p_busy), 32'd0);
    tick();
    tick();
    check_write("wr", 16'h0100, v1);

    // Collision with wrap: write taken, read dropped
    clear_mon();
    start_write(16'hFFF8, v2, 1'b1);
    wait_idle("wrap", 300);
    check_write("wrap", 16'hFFF8, v2);
    if (req_q.size() == 4) begin
      chk("wrap addr2", 32'(req_q[2].addr), 32'h0000);
      chk("wrap addr3", 32'(req_q[3].addr), 32'h0004);
    end

    // Requests while busy are dropped
    clear_mon();
    start_write(16'h0500, v1, 1'b0);
    n = 0;
    while (word_req && n < 20) begin
      tick();
      n++;
    end
    chk("busy in_wwait", 32'(word_req), 32'd0);
    wr_addr = 16'h0600;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wait_idle("busy", 300);
    check_write("busy", 16'h0500, v1);

`ifdef E2P_TIMEOUT_EN
    // Silent engine: timeout pulse, no completion
    clear_mon();
    eng_en = 1'b0;
    start_write(16'h0200, v1, 1'b0);
    wait_idle("to", 100);
    chk("to req_cycles", 32'(last_hi), 32'(TO + 1));
    chk("to nreq", 32'(req_q.size()), 32'd1);
    chk("to err", 32'(n_err), 32'd1);
    chk("to wr_done", 32'(n_done), 32'd0);
    eng_en = 1'b1;
`else
    // Silent engine: request held indefinitely, recovered by reset
    clear_mon();
    eng_en = 1'b0;
    start_write(16'h0200, v1, 1'b0);
    repeat (40) tick();
    chk("hold word_req", 32'(word_req), 32'd1);
    chk("hold busy", 32'(e2p_busy), 32'd1);
    chk("hold err", 32'(n_err), 32'd0);
    rst_sys_n = 1'b0;
    tick();
    rst_sys_n = 1'b1;
    eng_en = 1'b1;
    tick();
    chk("hold recovered", 32'(e2p_busy), 32'd0);
`endif

    // Reset in the wait after word 1
    clear_mon();
    start_write(16'h0700, v3, 1'b0);
    n = 0;
    while (!(req_q.size() == 2 && !word_req) && n < 200) begin
      tick();
      n++;
    end
    chk("mid nreq", 32'(req_q.size()), 32'd2);
    #3;
    rst_sys_n = 1'b0;
    #1;
    chk("mid word_req", 32'(word_req), 32'd0);
    chk("mid busy", 32'(e2p_busy), 32'd0);
    chk("mid word_addr", 32'(word_addr), 32'd0);
    chk("mid word_wdata", word_wdata, 32'd0);
    chk("mid rd_value", e2p_rd_value, 32'd0);
    tick();
    tick();
    clear_mon();
    rst_sys_n = 1'b1;
    repeat (30) tick();
    chk("mid no_req", 32'(req_q.size()), 32'd0);
    chk("mid no_done", 32'(n_done), 32'd0);
    chk("mid no_dval", 32'(n_dval), 32'd0);
    clear_mon();
    start_write(16'h0800, v3, 1'b0);
    wait_idle("restart", 300);
    check_write("restart", 16'h0800, v3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
